// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter splitting 32-bit accesses into two 16-bit SRAM phases
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam logic [2:0] WC = 3'(WAIT_CYCLES);
  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic        port_q, last_q, we_q;
  logic [16:0] addr_q;
  logic [31:0] wdata_q, rdata0_q, rdata1_q;
  logic [15:0] rlo_q;
  logic        gnt_any, gnt_port, phase_end, in_phase, drive;
  logic        unused_addr;
  assign unused_addr = ^{p0_addr[31:19], p0_addr[1:0], p1_addr[31:19], p1_addr[1:0]};
  assign gnt_any   = p0_req | p1_req;
  // on contention the port that did not win last time gets the grant
  assign gnt_port  = p1_req & (~p0_req | ~last_q);
  assign phase_end = cnt_q == WC;
  assign in_phase  = (state_q == LO) | (state_q == HI);
  assign drive     = we_q & in_phase;
  // next-state: each phase holds for WAIT_CYCLES+1 cycles, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = gnt_any ? LO : IDLE;
      LO:      state_d = phase_end ? HI : LO;
      HI:      state_d = phase_end ? DONE : HI;
      default: state_d = IDLE;
    endcase
  end
  // state register, phase counter, grant capture and read-data assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      port_q   <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rlo_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (in_phase && !phase_end) ? cnt_q + 3'd1 : 3'd0;
      if (state_q == IDLE && gnt_any) begin
        port_q  <= gnt_port;
        last_q  <= gnt_port;
        we_q    <= gnt_port ? p1_we : p0_we;
        addr_q  <= gnt_port ? p1_addr[18:2] : p0_addr[18:2];
        wdata_q <= gnt_port ? p1_wdata : p0_wdata;
      end
      if (state_q == LO && phase_end && !we_q)
        rlo_q <= SRAM_DQ;
      if (state_q == HI && phase_end && !we_q) begin
        if (port_q)
          rdata1_q <= {SRAM_DQ, rlo_q};
        else
          rdata0_q <= {SRAM_DQ, rlo_q};
      end
    end
  end
  assign SRAM_WE_N = ~drive;
  assign SRAM_DQ   = drive ? (state_q == HI ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;
  assign SRAM_ADDR = in_phase ? {addr_q, state_q == HI} : 18'd0;
  assign busy      = state_q != IDLE;
  assign p0_ready  = (state_q == DONE) & ~port_q;
  assign p1_ready  = (state_q == DONE) & port_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scoreboard bench for sram_arbiter with a behavioural SRAM
module tb_sram_arbiter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, lreq = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  wire [31:0] p0_rdata, p1_rdata, rd0, rd3, x0_rd, x3_rd;
  wire p0_ready, p1_ready, we_n, busy;
  wire r0_ready, r3_ready, x0_ready, x3_ready, we0_n, we3_n, busy0, busy3;
  wire [17:0] sa, a0, a3;
  wire [15:0] dq, dq0, dq3;
  logic [15:0] mem [0:255] = '{default: 16'h0};
  logic pl_en = 0;
  logic [7:0] pl_a = 0;
  logic [15:0] pl_d = 0;
  int n_pass = 0, n_total = 0, we_low = 0;
  typedef struct packed {logic port; logic rd; logic [31:0] data;} exp_t;
  exp_t sb[$];

  sram_arbiter #(.WAIT_CYCLES(1)) dut (.clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .SRAM_DQ(dq), .SRAM_ADDR(sa), .SRAM_WE_N(we_n), .busy(busy));
  sram_arbiter #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst),
    .p0_req(lreq), .p0_we(1'b0), .p0_addr(32'h40), .p0_wdata(32'h0), .p0_rdata(rd0), .p0_ready(r0_ready),
    .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0), .p1_rdata(x0_rd), .p1_ready(x0_ready),
    .SRAM_DQ(dq0), .SRAM_ADDR(a0), .SRAM_WE_N(we0_n), .busy(busy0));
  sram_arbiter #(.WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst),
    .p0_req(lreq), .p0_we(1'b0), .p0_addr(32'h40), .p0_wdata(32'h0), .p0_rdata(rd3), .p0_ready(r3_ready),
    .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0), .p1_rdata(x3_rd), .p1_ready(x3_ready),
    .SRAM_DQ(dq3), .SRAM_ADDR(a3), .SRAM_WE_N(we3_n), .busy(busy3));

  assign dq  = we_n ? mem[sa[7:0]] : 16'hzzzz;
  assign dq0 = we0_n ? (a0[0] ? 16'hC0DE : 16'hF00D) : 16'hzzzz;
  assign dq3 = we3_n ? (a3[0] ? 16'hC0DE : 16'hF00D) : 16'hzzzz;

  always @(posedge clk)
    if (!we_n) mem[sa[7:0]] <= dq;
    else if (pl_en) mem[pl_a] <= pl_d;

  always @(negedge clk) if (!we_n) we_low++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk)
    if (p0_ready || p1_ready) begin
      exp_t e;
      chk("ready_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ready_port", 32'(p1_ready), 32'(e.port));
        chk("ready_onehot", 32'(p0_ready & p1_ready), 32'd0);
        if (e.rd) chk("rdata", e.port ? p1_rdata : p0_rdata, e.data);
      end
    end

  task automatic drive(input logic port, req, we, input logic [31:0] addr, wdata);
    if (port) begin p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    else begin p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
  endtask

  task automatic wait_ready(input logic port, output int n);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (port ? p1_ready : p0_ready) break;
      @(posedge clk);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_a = a; pl_d = d; pl_en = 1;
    @(posedge clk); #1;
    pl_en = 0;
  endtask

  task automatic txn(input logic port, we, input logic [31:0] addr, wdata,
                     input logic rd, input logic [31:0] exp, input string tag);
    int n, base;
    @(posedge clk); #1;
    sb.push_back({port, rd, exp});
    base = we_low;
    drive(port, 1, we, addr, wdata);
    wait_ready(port, n);
    drive(port, 0, 0, 0, 0);
    chk({tag, "_latency"}, n, 6);
    chk({tag, "_we_low_cycles"}, we_low - base, we ? 4 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, seen, n0, n3;
    #1;
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_addr", 32'(sa), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", {30'd0, p1_ready, p0_ready}, 0);
    chk("rst_rdata0", p0_rdata, 0);
    chk("rst_rdata1", p1_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    txn(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, "p0_write");
    chk("mem8", 32'(mem[8]), 32'hBEEF);
    chk("mem9", 32'(mem[9]), 32'hDEAD);
    txn(1, 0, 32'h10, 0, 1, 32'hDEADBEEF, "p1_read");
    chk("p0_rdata_untouched", p0_rdata, 0);

    preload(8'h20, 16'h5678);
    preload(8'h21, 16'h1234);
    txn(0, 0, 32'h40, 0, 1, 32'h12345678, "p0_read");
    chk("p1_rdata_held", p1_rdata, 32'hDEADBEEF);
    txn(1, 1, 32'h40, 32'hCAFEF00D, 0, 0, "p1_write");
    chk("p1_rdata_after_write", p1_rdata, 32'hDEADBEEF);
    chk("mem20", 32'(mem[8'h20]), 32'hF00D);

    // request withdrawn during LO, while port 1 knocks only while busy
    @(posedge clk); #1;
    sb.push_back({1'b0, 1'b1, 32'hCAFEF00D});
    drive(0, 1, 0, 32'h40, 0);
    @(posedge clk);
    @(negedge clk);
    chk("drop_busy", 32'(busy), 1);
    chk("drop_lo_addr", 32'(sa), 32'h20);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 32'h10, 0);
    wait_ready(0, n);
    drive(1, 0, 0, 0, 0);
    chk("drop_completes", 32'(n < 60), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("drop_idle", 32'(busy), 0);
    chk("drop_sb_empty", sb.size(), 0);

    // reset during the high phase of a write
    preload(8'h61, 16'hAAAA);
    @(posedge clk); #1;
    drive(0, 1, 1, 32'hC0, 32'h11112222);
    n = 0;
    do begin @(negedge clk); n++; end while (!(sa[0] && !we_n) && n < 30);
    chk("abort_reached_hi", 32'(n < 30), 1);
    rst = 1;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("abort_we_n", 32'(we_n), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_addr", 32'(sa), 0);
    chk("abort_ready", 32'(p0_ready), 0);
    chk("abort_rdata0", p0_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_mem_lo", 32'(mem[8'h60]), 32'h2222);
    chk("abort_mem_hi", 32'(mem[8'h61]), 32'hAAAA);
    rst = 0;

    // simultaneous held requests alternate starting with port 0
    sb.push_back({1'b0, 1'b0, 32'h0});
    sb.push_back({1'b1, 1'b0, 32'h0});
    sb.push_back({1'b0, 1'b0, 32'h0});
    drive(0, 1, 1, 32'h100, 32'h0A0A0B0B);
    drive(1, 1, 1, 32'h104, 32'h0C0C0D0D);
    seen = 0;
    n = 0;
    while (seen < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (p0_ready || p1_ready) seen++;
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("alt_count", seen, 3);
    repeat (10) @(posedge clk);
    #1;
    chk("alt_sb_empty", sb.size(), 0);
    chk("alt_mem80", 32'(mem[8'h80]), 32'h0B0B);
    chk("alt_mem83", 32'(mem[8'h83]), 32'h0C0C);

    // latency scaling with WAIT_CYCLES 0 and 3
    @(posedge clk); #1;
    lreq = 1;
    fork
      begin
        n0 = 0;
        while (n0 < 60) begin
          @(negedge clk); n0++;
          if (r0_ready) break;
          @(posedge clk);
        end
      end
      begin
        n3 = 0;
        while (n3 < 60) begin
          @(negedge clk); n3++;
          if (r3_ready) break;
          @(posedge clk);
        end
      end
    join
    lreq = 0;
    chk("w0_latency", n0, 4);
    chk("w3_latency", n3, 10);
    chk("w0_rdata", rd0, 32'hC0DEF00D);
    chk("w3_rdata", rd3, 32'hC0DEF00D);
    repeat (20) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
